// File: rtl/ekf_stage_dispatch_pkg.sv
// Shared stage codes, FSM encodings and command layout for the EKF stage
// dispatcher and the EKF top it drives.
package ekf_stage_dispatch_pkg;

    typedef enum logic [2:0] {
        STG_IDLE  = 3'b000,
        STG_PRD   = 3'b001,
        STG_NEW   = 3'b010,
        STG_UPD   = 3'b011,
        STG_ASSOC = 3'b100
    } stage_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_BUSY  = 3'd3,
        S_GAP   = 3'd4
    } state_e;

    localparam int CMD_W = 67;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] arg0;
        logic [31:0] arg1;
    } cmd_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op != 3'b000) && (op <= 3'b100);
    endfunction

endpackage

// File: rtl/ekf_stage_dispatch_fifo.sv
// Command buffer for the stage dispatcher: power-of-two depth FIFO with a
// wrap bit on each pointer to tell full from empty.
module ekf_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 67
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/ekf_stage_dispatch.sv
// Sequences buffered host commands onto the EKF stage interface, one stage at
// a time, with a forced idle gap so the engine always sees a fresh stage edge.
module ekf_stage_dispatch
    import ekf_stage_dispatch_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TO_CYCLES  = 1024
) (
    input  logic               clk_i,
    input  logic               sys_rst_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [2:0]         cmd_op_i,
    input  logic signed [31:0] cmd_arg0_i,
    input  logic signed [31:0] cmd_arg1_i,
    output logic [2:0]         stage_val_o,
    input  logic               stage_rdy_i,
    output logic signed [31:0] vlr_o,
    output logic signed [31:0] alpha_o,
    output logic signed [31:0] rk_o,
    output logic signed [31:0] phi_o,
    output logic               done_pulse_o,
    output logic [2:0]         done_op_o,
    output logic               err_illegal_o,
    output logic               err_timeout_o,
    output logic [15:0]        cmd_count_o
);

    localparam int TW = $clog2(TO_CYCLES + 1);

    state_e             state_q;
    cmd_t               cur_q;
    logic [TW-1:0]      to_cnt_q;
    logic [2:0]         stage_val_q, done_op_q;
    logic signed [31:0] vlr_q, alpha_q, rk_q, phi_q;
    logic               done_pulse_q, err_illegal_q, err_timeout_q;
    logic [15:0]        cmd_count_q;

    cmd_t fifo_wdata, fifo_rdata;
    logic fifo_full, fifo_empty, fifo_push, fifo_pop, handshake;

    assign cmd_ready_o = !fifo_full && !sys_rst_i;
    assign handshake   = cmd_valid_i && cmd_ready_o;
    assign fifo_push   = handshake && is_legal_op(cmd_op_i);
    assign fifo_pop    = (state_q == S_IDLE) && !fifo_empty && stage_rdy_i;
    assign fifo_wdata  = '{op: cmd_op_i, arg0: cmd_arg0_i, arg1: cmd_arg1_i};

    ekf_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (sys_rst_i),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // The popped command is parked in cur_q so operands move only in S_LOAD.
    always_ff @(posedge clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state_q       <= S_IDLE;
            cur_q         <= '0;
            to_cnt_q      <= '0;
            stage_val_q   <= STG_IDLE;
            done_op_q     <= STG_IDLE;
            vlr_q         <= '0;
            alpha_q       <= '0;
            rk_q          <= '0;
            phi_q         <= '0;
            done_pulse_q  <= 1'b0;
            err_illegal_q <= 1'b0;
            err_timeout_q <= 1'b0;
            cmd_count_q   <= '0;
        end else begin
            done_pulse_q <= 1'b0;
            if (handshake && !is_legal_op(cmd_op_i)) err_illegal_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (fifo_pop) begin
                        cur_q   <= fifo_rdata;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (cur_q.op == STG_PRD) begin
                        vlr_q   <= $signed(cur_q.arg0);
                        alpha_q <= $signed(cur_q.arg1);
                    end else begin
                        rk_q    <= $signed(cur_q.arg0);
                        phi_q   <= $signed(cur_q.arg1);
                    end
                    to_cnt_q    <= '0;
                    stage_val_q <= cur_q.op;
                    state_q     <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (!stage_rdy_i) begin
                        state_q <= S_BUSY;
                    end else if (to_cnt_q == TW'(TO_CYCLES - 1)) begin
                        err_timeout_q <= 1'b1;
                        stage_val_q   <= STG_IDLE;
                        state_q       <= S_GAP;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                S_BUSY: begin
                    if (stage_rdy_i) begin
                        done_pulse_q <= 1'b1;
                        done_op_q    <= stage_val_q;
                        cmd_count_q  <= cmd_count_q + 16'd1;
                        stage_val_q  <= STG_IDLE;
                        state_q      <= S_GAP;
                    end
                end
                S_GAP:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign stage_val_o   = stage_val_q;
    assign vlr_o         = vlr_q;
    assign alpha_o       = alpha_q;
    assign rk_o          = rk_q;
    assign phi_o         = phi_q;
    assign done_pulse_o  = done_pulse_q;
    assign done_op_o     = done_op_q;
    assign err_illegal_o = err_illegal_q;
    assign err_timeout_o = err_timeout_q;
    assign cmd_count_o   = cmd_count_q;

endmodule

// File: tb/tb_ekf_stage_dispatch.sv
// Directed bench for ekf_stage_dispatch: stage issue, queueing, illegal ops,
// timeout, reset abort and completion counter wrap.
module tb_ekf_stage_dispatch;

    logic               clk;
    logic               sys_rst;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [2:0]         cmd_op;
    logic signed [31:0] cmd_arg0, cmd_arg1;
    logic [2:0]         stage_val;
    logic               stage_rdy;
    logic signed [31:0] vlr, alpha, rk, phi;
    logic               done_pulse;
    logic [2:0]         done_op;
    logic               err_illegal, err_timeout;
    logic [15:0]        cmd_count;

    int checks = 0;
    int errors = 0;

    ekf_stage_dispatch #(
        .FIFO_DEPTH (4),
        .TO_CYCLES  (16)
    ) dut (
        .clk_i         (clk),
        .sys_rst_i     (sys_rst),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_op_i      (cmd_op),
        .cmd_arg0_i    (cmd_arg0),
        .cmd_arg1_i    (cmd_arg1),
        .stage_val_o   (stage_val),
        .stage_rdy_i   (stage_rdy),
        .vlr_o         (vlr),
        .alpha_o       (alpha),
        .rk_o          (rk),
        .phi_o         (phi),
        .done_pulse_o  (done_pulse),
        .done_op_o     (done_op),
        .err_illegal_o (err_illegal),
        .err_timeout_o (err_timeout),
        .cmd_count_o   (cmd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_cmd(input logic [2:0] op, input logic [31:0] a0, input logic [31:0] a1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg0  = a0;
        cmd_arg1  = a1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_issue(output int zeros, output bit ok);
        zeros = 0;
        ok    = 1'b0;
        while (!ok && zeros < 40) begin
            tick();
            if (stage_val != 3'b000) ok = 1'b1;
            else zeros++;
        end
    endtask

    task automatic finish_stage(input int busy);
        stage_rdy = 1'b0;
        repeat (busy) tick();
        stage_rdy = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (2) tick();
        checks++;
        if (cmd_ready !== 1'b0 || stage_val !== 3'b000 || done_pulse !== 1'b0 || done_op !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: ready=%b stage=%b done=%b op=%b, want 0 000 0 000",
                     cmd_ready, stage_val, done_pulse, done_op);
        end
        checks++;
        if (vlr !== 0 || alpha !== 0 || rk !== 0 || phi !== 0 || cmd_count !== 16'd0 ||
            err_illegal !== 1'b0 || err_timeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_data: vlr=%h alpha=%h rk=%h phi=%h cnt=%h ei=%b et=%b, want all 0",
                     vlr, alpha, rk, phi, cmd_count, err_illegal, err_timeout);
        end
        sys_rst = 1'b0;
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release_ready: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_prd();
        int  zeros;
        bit  ok;
        bit  held;
        push_cmd(3'b001, 32'h0000_1000, 32'h0001_0000);
        wait_issue(zeros, ok);
        checks++;
        if (!ok || stage_val !== 3'b001) begin
            errors++;
            $display("[TB] FAIL prd_issue: stage=%b want 001", stage_val);
        end
        checks++;
        if (vlr !== 32'sh0000_1000 || alpha !== 32'sh0001_0000 || rk !== 0 || phi !== 0) begin
            errors++;
            $display("[TB] FAIL prd_operands: vlr=%h alpha=%h rk=%h phi=%h want 1000 10000 0 0",
                     vlr, alpha, rk, phi);
        end
        tick();
        stage_rdy = 1'b0;
        held = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (stage_val !== 3'b001 || done_pulse !== 1'b0 || vlr !== 32'sh0000_1000) held = 1'b0;
        end
        checks++;
        if (!held) begin
            errors++;
            $display("[TB] FAIL prd_hold: stage=%b done=%b vlr=%h want 001 0 1000", stage_val, done_pulse, vlr);
        end
        stage_rdy = 1'b1;
        tick();
        checks++;
        if (done_pulse !== 1'b1 || done_op !== 3'b001 || cmd_count !== 16'd1 || stage_val !== 3'b000) begin
            errors++;
            $display("[TB] FAIL prd_done: done=%b op=%b cnt=%0d stage=%b want 1 001 1 000",
                     done_pulse, done_op, cmd_count, stage_val);
        end
        tick();
        checks++;
        if (done_pulse !== 1'b0) begin
            errors++;
            $display("[TB] FAIL prd_done_width: done=%b want 0", done_pulse);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  exp_op [5];
        logic [31:0] exp_a0 [5];
        logic [31:0] exp_a1 [5];
        logic [2:0]  got_ready;
        bit          rdy_ok;
        int          zeros;
        bit          ok;
        bit          quiet;
        exp_op = '{3'b010, 3'b011, 3'b100, 3'b001, 3'b010};
        exp_a0 = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0033, 32'hFFFF_FF44, 32'h0000_0055};
        exp_a1 = '{32'h0000_0A11, 32'h0000_0A22, 32'h0000_0A33, 32'h0000_0A44, 32'h0000_0A55};
        stage_rdy = 1'b0;
        rdy_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (cmd_ready !== (i < 4)) rdy_ok = 1'b0;
            push_cmd(exp_op[i], exp_a0[i], exp_a1[i]);
        end
        got_ready = {2'b00, cmd_ready};
        checks++;
        if (!rdy_ok || got_ready !== 3'b000) begin
            errors++;
            $display("[TB] FAIL b2b_ready: sequence_ok=%b final_ready=%b want 1 0", rdy_ok, got_ready[0]);
        end
        stage_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_issue(zeros, ok);
            checks++;
            if (!ok || stage_val !== exp_op[i] || (i > 0 && zeros + 1 < 2)) begin
                errors++;
                $display("[TB] FAIL b2b_issue%0d: stage=%b gap=%0d want %b gap>=2", i, stage_val, zeros + 1, exp_op[i]);
            end
            checks++;
            if (exp_op[i] == 3'b001) begin
                if (vlr !== exp_a0[i] || alpha !== exp_a1[i] || rk !== exp_a0[2] || phi !== exp_a1[2]) begin
                    errors++;
                    $display("[TB] FAIL b2b_operands%0d: vlr=%h alpha=%h rk=%h phi=%h", i, vlr, alpha, rk, phi);
                end
            end else if (rk !== exp_a0[i] || phi !== exp_a1[i]) begin
                errors++;
                $display("[TB] FAIL b2b_operands%0d: rk=%h phi=%h want %h %h", i, rk, phi, exp_a0[i], exp_a1[i]);
            end
            finish_stage(3);
            checks++;
            if (done_pulse !== 1'b1 || done_op !== exp_op[i] || stage_val !== 3'b000) begin
                errors++;
                $display("[TB] FAIL b2b_done%0d: done=%b op=%b stage=%b want 1 %b 000",
                         i, done_pulse, done_op, stage_val, exp_op[i]);
            end
        end
        quiet = 1'b1;
        repeat (10) begin
            tick();
            if (stage_val !== 3'b000) quiet = 1'b0;
        end
        checks++;
        if (!quiet || cmd_count !== 16'd5) begin
            errors++;
            $display("[TB] FAIL b2b_fifth_dropped: quiet=%b cnt=%0d want 1 5", quiet, cmd_count);
        end
    endtask

    task automatic test_illegal();
        bit quiet;
        checks++;
        if (err_illegal !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL illegal_pre: err=%b ready=%b want 0 1", err_illegal, cmd_ready);
        end
        push_cmd(3'b111, 32'h1234_5678, 32'h9ABC_DEF0);
        push_cmd(3'b000, 32'h1, 32'h2);
        checks++;
        if (err_illegal !== 1'b1 || cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL illegal_flag: err=%b ready=%b want 1 1", err_illegal, cmd_ready);
        end
        quiet = 1'b1;
        repeat (10) begin
            tick();
            if (stage_val !== 3'b000) quiet = 1'b0;
        end
        checks++;
        if (!quiet || cmd_count !== 16'd5 || err_illegal !== 1'b1) begin
            errors++;
            $display("[TB] FAIL illegal_no_issue: quiet=%b cnt=%0d err=%b want 1 5 1", quiet, cmd_count, err_illegal);
        end
    endtask

    task automatic test_timeout();
        int zeros;
        bit ok;
        bit held;
        stage_rdy = 1'b0;
        push_cmd(3'b011, 32'h0000_0777, 32'h0000_0888);
        push_cmd(3'b010, 32'h0000_0999, 32'h0000_0AAA);
        stage_rdy = 1'b1;
        wait_issue(zeros, ok);
        checks++;
        if (!ok || stage_val !== 3'b011 || rk !== 32'sh777) begin
            errors++;
            $display("[TB] FAIL timeout_issue: stage=%b rk=%h want 011 777", stage_val, rk);
        end
        held = 1'b1;
        repeat (15) begin
            tick();
            if (stage_val !== 3'b011 || err_timeout !== 1'b0) held = 1'b0;
        end
        checks++;
        if (!held) begin
            errors++;
            $display("[TB] FAIL timeout_early: stage=%b err=%b want 011 0", stage_val, err_timeout);
        end
        tick();
        checks++;
        if (err_timeout !== 1'b1 || stage_val !== 3'b000 || done_pulse !== 1'b0 || cmd_count !== 16'd5) begin
            errors++;
            $display("[TB] FAIL timeout_fire: err=%b stage=%b done=%b cnt=%0d want 1 000 0 5",
                     err_timeout, stage_val, done_pulse, cmd_count);
        end
        wait_issue(zeros, ok);
        checks++;
        if (!ok || stage_val !== 3'b010 || rk !== 32'sh999 || phi !== 32'shAAA) begin
            errors++;
            $display("[TB] FAIL timeout_next: stage=%b rk=%h phi=%h want 010 999 aaa", stage_val, rk, phi);
        end
        finish_stage(2);
        checks++;
        if (done_pulse !== 1'b1 || done_op !== 3'b010 || cmd_count !== 16'd6 || err_timeout !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_next_done: done=%b op=%b cnt=%0d err=%b want 1 010 6 1",
                     done_pulse, done_op, cmd_count, err_timeout);
        end
    endtask

    task automatic test_reset_busy();
        int zeros;
        bit ok;
        bit quiet;
        push_cmd(3'b001, 32'h0000_0123, 32'h0000_0456);
        push_cmd(3'b100, 32'h0000_0789, 32'h0000_0ABC);
        wait_issue(zeros, ok);
        stage_rdy = 1'b0;
        repeat (2) tick();
        checks++;
        if (!ok || stage_val !== 3'b001) begin
            errors++;
            $display("[TB] FAIL rstbusy_pre: stage=%b want 001", stage_val);
        end
        #2 sys_rst = 1'b1;
        #1;
        checks++;
        if (stage_val !== 3'b000 || cmd_ready !== 1'b0 || vlr !== 0 || alpha !== 0 || rk !== 0 || phi !== 0) begin
            errors++;
            $display("[TB] FAIL rstbusy_async: stage=%b ready=%b vlr=%h alpha=%h rk=%h phi=%h want 000 0 0 0 0 0",
                     stage_val, cmd_ready, vlr, alpha, rk, phi);
        end
        checks++;
        if (done_pulse !== 1'b0 || done_op !== 3'b000 || err_illegal !== 1'b0 ||
            err_timeout !== 1'b0 || cmd_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL rstbusy_status: done=%b op=%b ei=%b et=%b cnt=%0d want 0 000 0 0 0",
                     done_pulse, done_op, err_illegal, err_timeout, cmd_count);
        end
        tick();
        sys_rst   = 1'b0;
        stage_rdy = 1'b1;
        quiet = 1'b1;
        repeat (10) begin
            tick();
            if (stage_val !== 3'b000) quiet = 1'b0;
        end
        checks++;
        if (!quiet || cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstbusy_fifo_flushed: quiet=%b ready=%b want 1 1", quiet, cmd_ready);
        end
    endtask

    task automatic test_count_wrap();
        int zeros;
        bit ok;
        force dut.cmd_count_q = 16'hFFFF;
        tick();
        release dut.cmd_count_q;
        tick();
        checks++;
        if (cmd_count !== 16'hFFFF) begin
            errors++;
            $display("[TB] FAIL wrap_preload: cnt=%h want ffff", cmd_count);
        end
        push_cmd(3'b001, 32'h0000_0001, 32'h0000_0002);
        wait_issue(zeros, ok);
        finish_stage(2);
        checks++;
        if (!ok || done_pulse !== 1'b1 || cmd_count !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL wrap_count: issued=%b done=%b cnt=%h want 1 1 0000", ok, done_pulse, cmd_count);
        end
    endtask

    initial begin
        sys_rst   = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_arg0  = '0;
        cmd_arg1  = '0;
        stage_rdy = 1'b1;
        test_reset();
        test_prd();
        test_back_to_back();
        test_illegal();
        test_timeout();
        test_reset_busy();
        test_count_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
